id_ex_operand_stage: RTL and testbench

- Decode-to-execute pipeline register for the Otter pipeline, directly upstream of the ALU; drives the ALU's srcA, srcB and alu_fun.
- Captures decoded instruction fields and selects the ALU operands.
- Applies EX/MEM and MEM/WB result forwarding to the registered operands.
- Supports stall, flush and bubble insertion.

---
 rtl/otter_pkg.sv | 33 +++
 rtl/fwd_mux.sv | 43 ++++
 rtl/id_ex_operand_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : otter_pkg
//  Purpose  : Shared constants for the Otter pipeline: datapath width,
//             ALU operation codes and ALU operand-select encodings.
//  Contents : XLEN, ALU_* op codes, SRCA_* / SRCB_* select values.
//  Revision : 1.0 - initial release
// ============================================================================
package otter_pkg;

   localparam int XLEN = 32;

   // ALU operation codes (bit 3 selects the "alternate" form: SUB, SRA)
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_LUI  = 4'b1001;

   // ALU operand selects
   localparam logic SRCA_RS1 = 1'b0;
   localparam logic SRCA_PC  = 1'b1;
   localparam logic SRCB_RS2 = 1'b0;
   localparam logic SRCB_IMM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_mux
//  Purpose  : Result-forwarding selector for one source operand. Picks the
//             newest in-flight producer of the register, falling back to the
//             registered register-file data.
//  Ports    : rs_addr/rs_data          - source register number and its data
//             exmem_* / memwb_*        - destination, write enable and result
//                                        of the two older instructions
//             fwd_data                 - forwarded operand value
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_mux #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rs_addr,
   input  logic [XLEN-1:0]       rs_data,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic                  exmem_reg_write,
   input  logic [XLEN-1:0]       exmem_result,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic                  memwb_reg_write,
   input  logic [XLEN-1:0]       memwb_result,
   output logic [XLEN-1:0]       fwd_data
);
   import otter_pkg::*;

   always_comb begin
      fwd_data = rs_data;
      // x0 is hardwired to zero, so a write to it must never be forwarded.
      // EX/MEM is checked first because it holds the younger producer.
      if (rs_addr != '0) begin
         if (exmem_reg_write && (exmem_rd == rs_addr)) begin
            fwd_data = exmem_result;
         end else if (memwb_reg_write && (memwb_rd == rs_addr)) begin
            fwd_data = memwb_result;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_operand_stage
//  Purpose  : ID/EX pipeline register for the Otter pipeline. Captures the
//             decoded instruction, forwards EX/MEM and MEM/WB results onto
//             the registered operands and drives the ALU inputs.
//             Supports stall (hold), flush (bubble) and bubble insertion.
//  Ports    : clk, rst (async, active high)
//             stall, flush            - pipeline control
//             id_*                    - decoded instruction from ID
//             exmem_*, memwb_*        - forwarding sources
//             ex_valid, srcA, srcB, alu_fun, ex_store_data, ex_pc,
//             ex_rd_addr, ex_reg_write, ex_mem_read - EX stage outputs
//             load_use_hazard         - load-use detect for the hazard unit
//  Config   : ID_EX_LOAD_USE_EN - when defined, generates the load-use
//             comparator; otherwise load_use_hazard is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
   parameter int XLEN       = otter_pkg::XLEN,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [XLEN-1:0]       id_pc,
   input  logic [REG_ADDR_W-1:0] id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] id_rs2_addr,
   input  logic [XLEN-1:0]       id_rs1_data,
   input  logic [XLEN-1:0]       id_rs2_data,
   input  logic [XLEN-1:0]       id_imm,
   input  logic                  id_srcA_sel,
   input  logic                  id_srcB_sel,
   input  logic [3:0]            id_alu_fun,
   input  logic [REG_ADDR_W-1:0] id_rd_addr,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic                  exmem_reg_write,
   input  logic                  memwb_reg_write,
   input  logic [XLEN-1:0]       exmem_result,
   input  logic [XLEN-1:0]       memwb_result,
   output logic                  ex_valid,
   output logic [XLEN-1:0]       srcA,
   output logic [XLEN-1:0]       srcB,
   output logic [3:0]            alu_fun,
   output logic [XLEN-1:0]       ex_store_data,
   output logic [XLEN-1:0]       ex_pc,
   output logic [REG_ADDR_W-1:0] ex_rd_addr,
   output logic                  ex_reg_write,
   output logic                  ex_mem_read,
   output logic                  load_use_hazard
);
   import otter_pkg::*;

   logic                  r_valid;
   logic [XLEN-1:0]       r_pc;
   logic [REG_ADDR_W-1:0] r_rs1_addr;
   logic [REG_ADDR_W-1:0] r_rs2_addr;
   logic [XLEN-1:0]       r_rs1_data;
   logic [XLEN-1:0]       r_rs2_data;
   logic [XLEN-1:0]       r_imm;
   logic                  r_srca_sel;
   logic                  r_srcb_sel;
   logic [3:0]            r_alu_fun;
   logic [REG_ADDR_W-1:0] r_rd_addr;
   logic                  r_reg_write;
   logic                  r_mem_read;

   logic [XLEN-1:0]       w_rs1_fwd;
   logic [XLEN-1:0]       w_rs2_fwd;

   // -------------------------------------------------------------------------
   // Pipeline register: flush > stall > load
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_pc        <= '0;
         r_rs1_addr  <= '0;
         r_rs2_addr  <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_srca_sel  <= 1'b0;
         r_srcb_sel  <= 1'b0;
         r_alu_fun   <= 4'b0000;
         r_rd_addr   <= '0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (flush) begin
         // Only the control bits matter for a bubble; the datapath fields
         // are left alone.
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
      end else if (stall) begin
         // While held, a producer may retire out of EX/MEM or MEM/WB and its
         // result would no longer be forwardable. Capture the forwarded
         // values now so the operands survive the stall.
         if (r_valid) begin
            r_rs1_data <= w_rs1_fwd;
            r_rs2_data <= w_rs2_fwd;
         end
      end else begin
         r_valid     <= id_valid;
         r_pc        <= id_pc;
         r_rs1_addr  <= id_rs1_addr;
         r_rs2_addr  <= id_rs2_addr;
         r_rs1_data  <= id_rs1_data;
         r_rs2_data  <= id_rs2_data;
         r_imm       <= id_imm;
         r_srca_sel  <= id_srcA_sel;
         r_srcb_sel  <= id_srcB_sel;
         r_alu_fun   <= id_alu_fun;
         r_rd_addr   <= id_rd_addr;
         // A non-valid ID slot enters EX as a bubble with no side effects.
         r_reg_write <= id_valid & id_reg_write;
         r_mem_read  <= id_valid & id_mem_read;
      end
   end

   // -------------------------------------------------------------------------
   // Operand forwarding
   // -------------------------------------------------------------------------
   fwd_mux #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_rs1 (
      .rs_addr         (r_rs1_addr),
      .rs_data         (r_rs1_data),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_result    (exmem_result),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_result    (memwb_result),
      .fwd_data        (w_rs1_fwd)
   );

   fwd_mux #(
      .XLEN       (XLEN),
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_rs2 (
      .rs_addr         (r_rs2_addr),
      .rs_data         (r_rs2_data),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .exmem_result    (exmem_result),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .memwb_result    (memwb_result),
      .fwd_data        (w_rs2_fwd)
   );

   // -------------------------------------------------------------------------
   // EX outputs
   // -------------------------------------------------------------------------
   assign srcA          = (r_srca_sel == SRCA_PC)  ? r_pc  : w_rs1_fwd;
   assign srcB          = (r_srcb_sel == SRCB_IMM) ? r_imm : w_rs2_fwd;
   assign ex_store_data = w_rs2_fwd;
   assign alu_fun       = r_alu_fun;
   assign ex_pc         = r_pc;
   assign ex_rd_addr    = r_rd_addr;
   assign ex_valid      = r_valid;
   assign ex_reg_write  = r_valid & r_reg_write;
   assign ex_mem_read   = r_valid & r_mem_read;

`ifdef ID_EX_LOAD_USE_EN
   // A load in EX whose destination is read by the instruction in ID cannot
   // be forwarded in time; the hazard unit stalls and inserts a bubble.
   assign load_use_hazard = r_valid && r_mem_read && id_valid &&
                            (r_rd_addr != '0) &&
                            ((r_rd_addr == id_rs1_addr) || (r_rd_addr == id_rs2_addr));
`else
   assign load_use_hazard = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_operand_stage
//  Purpose  : Self-checking bench for id_ex_operand_stage. Expected EX
//             contents are queued when an instruction is driven and compared
//             when it appears on the EX outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;
   import otter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, id_valid;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic        id_srcA_sel, id_srcB_sel, id_reg_write, id_mem_read;
   logic [3:0]  id_alu_fun;
   logic [4:0]  exmem_rd, memwb_rd;
   logic        exmem_reg_write, memwb_reg_write;
   logic [31:0] exmem_result, memwb_result;
   logic        ex_valid, ex_reg_write, ex_mem_read, load_use_hazard;
   logic [31:0] srcA, srcB, ex_store_data, ex_pc;
   logic [3:0]  alu_fun;
   logic [4:0]  ex_rd_addr;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          ctrl_only;
      logic        valid;
      logic [31:0] srca;
      logic [31:0] srcb;
      logic [3:0]  fun;
      logic [31:0] store;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   id_ex_operand_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .flush           (flush),
      .id_valid        (id_valid),
      .id_pc           (id_pc),
      .id_rs1_addr     (id_rs1_addr),
      .id_rs2_addr     (id_rs2_addr),
      .id_rs1_data     (id_rs1_data),
      .id_rs2_data     (id_rs2_data),
      .id_imm          (id_imm),
      .id_srcA_sel     (id_srcA_sel),
      .id_srcB_sel     (id_srcB_sel),
      .id_alu_fun      (id_alu_fun),
      .id_rd_addr      (id_rd_addr),
      .id_reg_write    (id_reg_write),
      .id_mem_read     (id_mem_read),
      .exmem_rd        (exmem_rd),
      .memwb_rd        (memwb_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_reg_write (memwb_reg_write),
      .exmem_result    (exmem_result),
      .memwb_result    (memwb_result),
      .ex_valid        (ex_valid),
      .srcA            (srcA),
      .srcB            (srcB),
      .alu_fun         (alu_fun),
      .ex_store_data   (ex_store_data),
      .ex_pc           (ex_pc),
      .ex_rd_addr      (ex_rd_addr),
      .ex_reg_write    (ex_reg_write),
      .ex_mem_read     (ex_mem_read),
      .load_use_hazard (load_use_hazard)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic id_instr(input logic v, input logic [31:0] pc,
                           input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [31:0] imm, input logic sa, input logic sbs,
                           input logic [3:0] fun, input logic [4:0] rd,
                           input logic rw, input logic mr);
      id_valid = v;   id_pc = pc;
      id_rs1_addr = rs1; id_rs1_data = d1;
      id_rs2_addr = rs2; id_rs2_data = d2;
      id_imm = imm;   id_srcA_sel = sa; id_srcB_sel = sbs;
      id_alu_fun = fun; id_rd_addr = rd;
      id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic fwd(input logic [4:0] er, input logic ew, input logic [31:0] eres,
                      input logic [4:0] mrd, input logic mw, input logic [31:0] mres);
      exmem_rd = er; exmem_reg_write = ew; exmem_result = eres;
      memwb_rd = mrd; memwb_reg_write = mw; memwb_result = mres;
   endtask

   task automatic push(input bit co, input logic v, input logic [31:0] sa,
                       input logic [31:0] sbv, input logic [3:0] fun,
                       input logic [31:0] st, input logic [31:0] pc,
                       input logic [4:0] rd, input logic rw, input logic mr);
      exp_t e;
      e.ctrl_only = co; e.valid = v; e.srca = sa; e.srcb = sbv; e.fun = fun;
      e.store = st; e.pc = pc; e.rd = rd; e.rw = rw; e.mr = mr;
      sb.push_back(e);
   endtask

   task automatic check_ex();
      exp_t e;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.valid});
      chk("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, e.rw});
      chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, e.mr});
      if (!e.ctrl_only) begin
         chk("srcA", srcA, e.srca);
         chk("srcB", srcB, e.srcb);
         chk("alu_fun", {28'd0, alu_fun}, {28'd0, e.fun});
         chk("ex_store_data", ex_store_data, e.store);
         chk("ex_pc", ex_pc, e.pc);
         chk("ex_rd_addr", {27'd0, ex_rd_addr}, {27'd0, e.rd});
      end
   endtask

   // Advance one active edge and compare the oldest expected entry.
   task automatic tick_check();
      @(posedge clk);
      #1;
      check_ex();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, ex_valid}, 32'd0);
      chk({tag, "_srcA"}, srcA, 32'd0);
      chk({tag, "_srcB"}, srcB, 32'd0);
      chk({tag, "_alu_fun"}, {28'd0, alu_fun}, 32'd0);
      chk({tag, "_store"}, ex_store_data, 32'd0);
      chk({tag, "_pc"}, ex_pc, 32'd0);
      chk({tag, "_rd"}, {27'd0, ex_rd_addr}, 32'd0);
      chk({tag, "_rw"}, {31'd0, ex_reg_write}, 32'd0);
      chk({tag, "_mr"}, {31'd0, ex_mem_read}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      id_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
      fwd(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");

      // Plain load: rs1 + imm
      @(negedge clk);
      rst = 1'b0;
      id_instr(1, 32'h100, 5'd1, 32'd5, 5'd6, 32'd9, 32'd7, SRCA_RS1, SRCB_IMM, ALU_ADD, 5'd2, 1, 0);
      push(0, 1, 32'd5, 32'd7, ALU_ADD, 32'd9, 32'h100, 5'd2, 1, 0);
      tick_check();

      // EX/MEM beats MEM/WB for the same register
      @(negedge clk);
      id_instr(1, 32'h104, 5'd3, 32'h99, 5'd7, 32'h44, 32'h0, SRCA_RS1, SRCB_RS2, ALU_SUB, 5'd8, 1, 0);
      fwd(5'd3, 1, 32'h11, 5'd3, 1, 32'h22);
      push(0, 1, 32'h11, 32'h44, ALU_SUB, 32'h44, 32'h104, 5'd8, 1, 0);
      tick_check();
      // Drop EX/MEM write enable: MEM/WB now supplies the value
      exmem_reg_write = 1'b0;
      push(0, 1, 32'h22, 32'h44, ALU_SUB, 32'h44, 32'h104, 5'd8, 1, 0);
      #1;
      check_ex();

      // x0 is never forwarded on either operand
      @(negedge clk);
      id_instr(1, 32'h108, 5'd0, 32'h33, 5'd0, 32'h0, 32'h0, SRCA_RS1, SRCB_RS2, ALU_OR, 5'd0, 0, 0);
      fwd(5'd0, 1, 32'hFF, 5'd0, 1, 32'hEE);
      push(0, 1, 32'h33, 32'h0, ALU_OR, 32'h0, 32'h108, 5'd0, 0, 0);
      tick_check();

      // srcA from PC, srcB from imm, store data from rs2
      @(negedge clk);
      id_instr(1, 32'h200, 5'd1, 32'h1, 5'd2, 32'h55, 32'h3000, SRCA_PC, SRCB_IMM, ALU_LUI, 5'd9, 1, 0);
      fwd(5'd0, 0, 32'h0, 5'd0, 0, 32'h0);
      push(0, 1, 32'h200, 32'h3000, ALU_LUI, 32'h55, 32'h200, 5'd9, 1, 0);
      tick_check();

      // Stall refresh: rs1 forwarded from MEM/WB, producer retires mid-stall
      @(negedge clk);
      id_instr(1, 32'h10C, 5'd4, 32'h01, 5'd5, 32'h02, 32'h10, SRCA_RS1, SRCB_IMM, ALU_AND, 5'd6, 1, 0);
      fwd(5'd0, 0, 32'h0, 5'd4, 1, 32'hAB);
      push(0, 1, 32'hAB, 32'h10, ALU_AND, 32'h02, 32'h10C, 5'd6, 1, 0);
      tick_check();
      @(negedge clk);
      stall = 1'b1;
      id_instr(1, 32'h500, 5'd9, 32'h77, 5'd10, 32'h88, 32'h99, SRCA_PC, SRCB_RS2, ALU_XOR, 5'd11, 0, 1);
      push(0, 1, 32'hAB, 32'h10, ALU_AND, 32'h02, 32'h10C, 5'd6, 1, 0);
      tick_check();
      @(negedge clk);
      memwb_reg_write = 1'b0;
      push(0, 1, 32'hAB, 32'h10, ALU_AND, 32'h02, 32'h10C, 5'd6, 1, 0);
      tick_check();

      // Bubble: id_valid=0 must not carry write/load side effects
      @(negedge clk);
      stall = 1'b0;
      id_instr(0, 32'h110, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, SRCA_RS1, SRCB_RS2, ALU_ADD, 5'd3, 1, 1);
      push(1, 0, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'h0, 5'd0, 0, 0);
      tick_check();

      // Load into x5 in EX, then an ID consumer of x5
      @(negedge clk);
      id_instr(1, 32'h114, 5'd1, 32'h1000, 5'd0, 32'h0, 32'h4, SRCA_RS1, SRCB_IMM, ALU_ADD, 5'd5, 1, 1);
      push(0, 1, 32'h1000, 32'h4, ALU_ADD, 32'h0, 32'h114, 5'd5, 1, 1);
      tick_check();
      id_instr(1, 32'h118, 5'd7, 32'h0, 5'd5, 32'h0, 32'h0, SRCA_RS1, SRCB_RS2, ALU_ADD, 5'd12, 1, 0);
      #1;
`ifdef ID_EX_LOAD_USE_EN
      chk("load_use_hazard", {31'd0, load_use_hazard}, 32'd1);
`else
      chk("load_use_hazard", {31'd0, load_use_hazard}, 32'd0);
`endif

      // Flush and stall on the same edge: bubble wins
      @(negedge clk);
      flush = 1'b1; stall = 1'b1;
      push(1, 0, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'h0, 5'd0, 0, 0);
      tick_check();
      chk("load_use_after_flush", {31'd0, load_use_hazard}, 32'd0);

      // Flush alone with a valid ID instruction
      @(negedge clk);
      stall = 1'b0;
      id_instr(1, 32'h11C, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, SRCA_RS1, SRCB_RS2, ALU_SLT, 5'd13, 1, 1);
      push(1, 0, 32'h0, 32'h0, ALU_ADD, 32'h0, 32'h0, 5'd0, 0, 0);
      tick_check();

      // Valid instruction, then asynchronous reset between edges
      @(negedge clk);
      flush = 1'b0;
      id_instr(1, 32'h120, 5'd1, 32'h3, 5'd2, 32'h4, 32'h0, SRCA_RS1, SRCB_RS2, ALU_SRA, 5'd14, 1, 0);
      push(0, 1, 32'h3, 32'h4, ALU_SRA, 32'h4, 32'h120, 5'd14, 1, 0);
      tick_check();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;

      if (sb.size() != 0) begin
         chk("scoreboard_leftover", sb.size(), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
